fx_match_arbiter: RTL and testbench
===================================

FX_MATCH_ARBITER -- requirements
Module: fx_match_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the format-match pipeline; 2..8.
REQ-002 Parameter IN_W, default 12: input sample width, two's complement.
REQ-003 Parameter OUT_W, default 14: output sample width; OUT_W >= IN_W.
REQ-004 Parameter DELAY, default 3: pipeline depth in cycles from accept to output; >= 1.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 i_valid  input  N_REQ  per-requester sample-valid.
REQ-008 i_data  input  N_REQ*IN_W  flattened samples; requester k occupies bits [k*IN_W +: IN_W].
REQ-009 i_hold  input  1  when high, no new grants; pipeline keeps draining.
REQ-010 o_ready  output  N_REQ  one-hot grant, combinational from i_valid, i_hold and the pointer.
REQ-011 o_valid  output  1  registered output-sample valid.
REQ-012 o_id  output  clog2(N_REQ)  requester index of the current output sample.
REQ-013 o_data  output  OUT_W  sign-extended output sample.
REQ-014 o_busy  output  1  high while any pipeline stage holds a valid sample.
REQ-015 o_issue_cnt  output  16  accepted-sample count (see Configuration).

Function
REQ-016 Transfer from requester k occurs in a cycle where i_valid[k] and o_ready[k] are both high.
REQ-017 o_ready has at most one bit set and is all-zero when i_hold=1, when rst=1, or when i_valid=0.
REQ-018 Round-robin arbitration: grant the lowest index k, searching ptr, ptr+1, ... mod N_REQ, with i_valid[k]=1.
REQ-019 After a grant to k, ptr becomes (k+1) mod N_REQ; without a grant, ptr is unchanged.
REQ-020 Width conversion: o_data = IN_W-bit sample with its MSB replicated (OUT_W-IN_W) times; LSBs pass through unchanged; no rounding or saturation.
REQ-021 Pipeline: DELAY stages of {valid, id, data} advancing every cycle unconditionally; no backpressure from the output.
REQ-022 Latency: a sample accepted in cycle t appears on o_valid/o_id/o_data in cycle t+DELAY for exactly one cycle.
REQ-023 Throughput: one accept per cycle sustained; back-to-back grants to different requesters are allowed.
REQ-024 Non-valid stages carry valid=0; o_id and o_data hold their last values when o_valid=0.
REQ-025 o_busy is the OR of all stage valid bits, including the output register.
REQ-026 If i_hold rises while samples are in flight, those samples still emerge on schedule.

Reset
REQ-027 While rst=1, in the next cycle: ptr=0, all stage valids=0, o_valid=0, o_id=0, o_data=0, o_busy=0, o_issue_cnt=0.
REQ-028 A reset asserted mid-operation discards in-flight samples; none emerge afterwards.
REQ-029 The first grant is possible in the first cycle with rst=0.

Configuration
REQ-030 Macro FX_MATCH_ARB_ISSUE_CNT_EN defined: o_issue_cnt increments by 1 per transfer and saturates at 0xFFFF.
REQ-031 Macro FX_MATCH_ARB_ISSUE_CNT_EN undefined: no counter logic is present and o_issue_cnt is constant 0.

Verification
REQ-032 N_REQ=4, DELAY=3: all i_valid=1 for 8 cycles after reset -> grants in order 0,1,2,3,0,1,2,3; o_id follows the same order starting 3 cycles after the first grant.
REQ-033 Only requester 2 valid with i_data=0x800 -> o_ready=0100; 3 cycles later o_valid=1, o_id=2, o_data=0x3800.
REQ-034 Requester 1 valid with sample 0x7FF and i_hold=1 for 2 cycles, then 0 -> no grant while held; then grant; o_data=0x07FF 3 cycles after the grant.
REQ-035 Pipeline full with 3 samples, rst pulsed for 1 cycle -> o_valid stays 0 and o_busy=0 after reset; ptr=0, so the next grant goes to the lowest valid index.
REQ-036 With the macro defined, 70000 consecutive accepts -> o_issue_cnt=0xFFFF; with the macro undefined, o_issue_cnt=0 throughout.

Source files
------------

// File: rtl/fx_match_arbiter.sv
// Round-robin arbiter feeding a fixed-latency sign-extension pipeline.
// Optional accepted-sample counter enabled by FX_MATCH_ARB_ISSUE_CNT_EN.
module fx_match_arbiter #(
  parameter int N_REQ = 4,
  parameter int IN_W  = 12,
  parameter int OUT_W = 14,
  parameter int DELAY = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           i_valid,
  input  logic [N_REQ*IN_W-1:0]      i_data,
  input  logic                       i_hold,
  output logic [N_REQ-1:0]           o_ready,
  output logic                       o_valid,
  output logic [$clog2(N_REQ)-1:0]   o_id,
  output logic [OUT_W-1:0]           o_data,
  output logic                       o_busy,
  output logic [15:0]                o_issue_cnt
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             grant_s;
  logic [ID_W-1:0]  grant_id_s;
  logic [IN_W-1:0]  grant_samp_s;
  logic [OUT_W-1:0] grant_data_s;

  logic [DELAY-1:0] vld_q, vld_d;
  logic [ID_W-1:0]  id_q   [DELAY];
  logic [ID_W-1:0]  id_d   [DELAY];
  logic [OUT_W-1:0] data_q [DELAY];
  logic [OUT_W-1:0] data_d [DELAY];

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return sum[ID_W-1:0];
  endfunction

  // Round-robin search starting at the pointer; first valid requester wins.
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = '0;
    o_ready    = '0;
    if (!rst && !i_hold) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_s && i_valid[wrap_idx(ptr_q, i)]) begin
          grant_s    = 1'b1;
          grant_id_s = wrap_idx(ptr_q, i);
        end else begin
          grant_s    = grant_s;
        end
      end
      o_ready = grant_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id_s) : '0;
    end else begin
      o_ready = '0;
    end
  end

  // Sign-extend the granted sample: fill with its MSB, then overlay the LSBs.
  always_comb begin
    grant_samp_s = i_data[grant_id_s*IN_W +: IN_W];
    grant_data_s = {OUT_W{grant_samp_s[IN_W-1]}};
    grant_data_s[IN_W-1:0] = grant_samp_s;
  end

  // Next state: pointer advance and unconditional pipeline shift.
  always_comb begin
    ptr_d     = grant_s ? wrap_idx(grant_id_s, 1) : ptr_q;
    vld_d     = '0;
    vld_d[0]  = grant_s;
    id_d[0]   = grant_id_s;
    data_d[0] = grant_data_s;
    for (int i = 1; i < DELAY; i++) begin
      vld_d[i]  = vld_q[i-1];
      id_d[i]   = id_q[i-1];
      data_d[i] = data_q[i-1];
    end
    // The output stage keeps its last id/data when nothing valid arrives.
    id_d[DELAY-1]   = vld_d[DELAY-1] ? id_d[DELAY-1]   : id_q[DELAY-1];
    data_d[DELAY-1] = vld_d[DELAY-1] ? data_d[DELAY-1] : data_q[DELAY-1];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < DELAY; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      for (int i = 0; i < DELAY; i++) begin
        id_q[i]   <= id_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign o_valid = vld_q[DELAY-1];
  assign o_id    = id_q[DELAY-1];
  assign o_data  = data_q[DELAY-1];
  assign o_busy  = |vld_q;

`ifdef FX_MATCH_ARB_ISSUE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating transfer counter.
  always_comb begin
    if (grant_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_issue_cnt = cnt_q;
`else
  assign o_issue_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fx_match_arbiter.sv
// Self-checking bench: cycle-by-cycle queue model plus hand-computed directed checks.
module tb_fx_match_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid;
  logic [47:0] data;
  logic        hold;
  logic [3:0]  o_ready;
  logic        o_valid;
  logic [1:0]  o_id;
  logic [13:0] o_data;
  logic        o_busy;
  logic [15:0] o_issue_cnt;

  int checks = 0;
  int errors = 0;

  fx_match_arbiter #(.N_REQ(4), .IN_W(12), .OUT_W(14), .DELAY(3)) dut (
    .clk(clk), .rst(rst), .i_valid(valid), .i_data(data), .i_hold(hold),
    .o_ready(o_ready), .o_valid(o_valid), .o_id(o_id), .o_data(o_data),
    .o_busy(o_busy), .o_issue_cnt(o_issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] md(input int seed);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*12 +: 12] = 12'((seed * 389 + k * 1021 + 7) % 4096);
    return r;
  endfunction

  // Model: a queue of samples tagged with the cycle they are due at the output.
  typedef struct { int due; int id; int dat; } item_t;
  item_t q[$];
  int  m_ptr = 0, last_id = 0, last_dat = 0, m_cnt = 0, cyc = 0;
  bit  armed = 1'b0;

  always @(negedge clk) begin
    int gk, k, ev, samp, s;
    item_t it;
    cyc++;
    gk = -1;
    if (!rst && !hold) begin
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (gk < 0 && valid[k]) gk = k;
      end
    end
    if (armed) begin
      ev = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev = 1; last_id = q[0].id; last_dat = q[0].dat;
      end
      chk("m_ready", o_ready, (gk >= 0) ? (1 << gk) : 0);
      chk("m_valid", o_valid, ev);
      chk("m_id", o_id, last_id);
      chk("m_data", o_data, last_dat);
      chk("m_busy", o_busy, (q.size() > 0) ? 1 : 0);
      chk("m_cnt", o_issue_cnt, m_cnt);
      if (ev) void'(q.pop_front());
    end
    if (rst) begin
      m_ptr = 0; q.delete(); last_id = 0; last_dat = 0; m_cnt = 0; armed = 1'b1;
    end else if (gk >= 0) begin
      samp = int'(data[gk*12 +: 12]);
      s = (samp >= 2048) ? samp - 4096 : samp;
      it.due = cyc + 3; it.id = gk; it.dat = (s + 16384) % 16384;
      q.push_back(it);
      m_ptr = (gk + 1) % 4;
`ifdef FX_MATCH_ARB_ISSUE_CNT_EN
      if (m_cnt < 65535) m_cnt++;
`endif
    end
  end

  task automatic cyc_in(input logic [3:0] v, input logic [47:0] d, input logic h, input logic r);
    @(posedge clk); #1;
    valid = v; data = d; hold = h; rst = r;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; valid = '0; data = '0; hold = 1'b0;
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    cyc_in(4'h0, 48'h0, 1'b0, 1'b1);
    cyc_in(4'h0, 48'h0, 1'b0, 1'b1);
    cyc_in(4'h0, 48'h0, 1'b0, 1'b0); mid();
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_id", o_id, 0);
    chk("rst_data", o_data, 0);
    chk("rst_cnt", o_issue_cnt, 0);

    // All requesters valid: strict rotation, ids emerge three cycles later.
    for (int i = 0; i < 8; i++) begin
      cyc_in(4'hF, md(i), 1'b0, 1'b0); mid();
      chk("rr_grant", o_ready, 1 << (i % 4));
      if (i >= 3) begin
        chk("rr_out_valid", o_valid, 1);
        chk("rr_out_id", o_id, (i - 3) % 4);
      end
    end
    for (int j = 0; j < 3; j++) begin
      cyc_in(4'h0, 48'h0, 1'b0, 1'b0); mid();
      chk("rr_tail_id", o_id, j + 1);
    end
    cyc_in(4'h0, 48'h0, 1'b0, 1'b0); mid();
    chk("drain_busy", o_busy, 0);

    // Negative full-scale from requester 2.
    cyc_in(4'b0100, 48'h000_800_000_000, 1'b0, 1'b0); mid();
    chk("neg_grant", o_ready, 4'b0100);
    for (int j = 0; j < 3; j++) cyc_in(4'h0, 48'h0, 1'b0, 1'b0);
    mid();
    chk("neg_valid", o_valid, 1);
    chk("neg_id", o_id, 2);
    chk("neg_data", o_data, 14'h3800);

    // Hold blocks requester 1, output holds last value meanwhile.
    for (int j = 0; j < 2; j++) begin
      cyc_in(4'b0010, 48'h000_000_7FF_000, 1'b1, 1'b0); mid();
      chk("hold_grant", o_ready, 0);
      chk("hold_out_data", o_data, 14'h3800);
    end
    cyc_in(4'b0010, 48'h000_000_7FF_000, 1'b0, 1'b0); mid();
    chk("unhold_grant", o_ready, 4'b0010);
    for (int j = 0; j < 3; j++) cyc_in(4'h0, 48'h0, 1'b0, 1'b0);
    mid();
    chk("pos_data", o_data, 14'h07FF);
    chk("pos_id", o_id, 1);

    // Hold rising with a sample in flight.
    cyc_in(4'hF, md(20), 1'b0, 1'b0);
    cyc_in(4'hF, md(21), 1'b1, 1'b0);
    cyc_in(4'b1001, md(22), 1'b1, 1'b0);
    cyc_in(4'h0, 48'h0, 1'b0, 1'b0); mid();
    chk("inflight_valid", o_valid, 1);
    chk("inflight_id", o_id, 2);
    cyc_in(4'h0, 48'h0, 1'b0, 1'b0);

    // Reset with a full pipeline discards everything.
    for (int j = 0; j < 3; j++) cyc_in(4'hF, md(30 + j), 1'b0, 1'b0);
    cyc_in(4'hF, md(33), 1'b0, 1'b1); mid();
    chk("rst_mid_ready", o_ready, 0);
    cyc_in(4'b1010, md(34), 1'b0, 1'b0); mid();
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_valid", o_valid, 0);
    chk("post_rst_grant", o_ready, 4'b0010);
    for (int j = 0; j < 2; j++) begin
      cyc_in(4'h0, 48'h0, 1'b0, 1'b0); mid();
      chk("post_rst_quiet", o_valid, 0);
    end
    cyc_in(4'h0, 48'h0, 1'b0, 1'b0); mid();
    chk("post_rst_first_id", o_id, 1);

    // Mixed valid/hold patterns, checked by the model.
    for (int i = 0; i < 16; i++) begin
      cyc_in(4'((i * 7 + 3) % 16), md(40 + i), ((i % 5) == 2) ? 1'b1 : 1'b0, 1'b0);
    end
    for (int j = 0; j < 4; j++) cyc_in(4'h0, 48'h0, 1'b0, 1'b0);

`ifdef FX_MATCH_ARB_ISSUE_CNT_EN
    for (int i = 0; i < 70000; i++) cyc_in(4'hF, md(i), 1'b0, 1'b0);
    cyc_in(4'h0, 48'h0, 1'b0, 1'b0); mid();
    chk("cnt_saturated", o_issue_cnt, 16'hFFFF);
`else
    mid();
    chk("cnt_absent", o_issue_cnt, 0);
`endif
    cyc_in(4'h0, 48'h0, 1'b0, 1'b0); mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
